// File: rtl/alu_mc_ctrl_if.sv
// Bundle of the upstream operation handshake, the ALU operand/result ports
// and the downstream result handshake for alu_mc_ctrl.
interface alu_mc_ctrl_if #(
    parameter int TAG_W = 4
);
    // valid/ready: a transfer happens on a rising clk edge where both are high;
    // the producer holds valid and payload stable until that edge.
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic             in_c;
    logic [TAG_W-1:0] in_tag;

    logic             alu_sel;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic             alu_c;
    logic [31:0]      alu_r;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_r;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_sel, in_a, in_b, in_c, in_tag, alu_r, out_ready,
        output in_ready, alu_sel, alu_a, alu_b, alu_c, out_valid, out_r, out_tag
    );

    modport master (
        output in_valid, in_sel, in_a, in_b, in_c, in_tag, alu_r, out_ready,
        input  in_ready, alu_sel, alu_a, alu_b, alu_c, out_valid, out_r, out_tag
    );
endinterface

// File: rtl/alu_mc_ctrl.sv
// Flow control around a fixed-latency pipelined ALU: tracks accepted slots,
// captures their results into a credit-protected FIFO, returns them in order.
module alu_mc_ctrl #(
    parameter int STAGES     = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu_mc_ctrl_if.slave  bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [STAGES-1:0] r_trk_vld;
    logic [TAG_W-1:0]  r_trk_tag [STAGES];
    logic [31:0]       r_mem_r   [FIFO_DEPTH];
    logic [TAG_W-1:0]  r_mem_tag [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_occ;
    logic [CNT_W-1:0]  r_count;

    logic w_in_ready;
    logic w_accept;
    logic w_wr;
    logic w_pop;
    logic w_out_valid;
    logic w_full;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credits cover in-flight plus buffered results, so in_ready is purely registered.
    assign w_in_ready  = (r_count < CNT_W'(FIFO_DEPTH)) && !rst;
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_wr        = r_trk_vld[STAGES-1];
    assign w_out_valid = (r_occ != '0);
    assign w_pop       = w_out_valid && bus.out_ready;
    assign w_full      = (r_occ == CNT_W'(FIFO_DEPTH));

    assign bus.in_ready  = w_in_ready;
    assign bus.alu_sel   = bus.in_sel;
    assign bus.alu_a     = bus.in_a;
    assign bus.alu_b     = bus.in_b;
    assign bus.alu_c     = bus.in_c;
    assign bus.out_valid = w_out_valid;
    assign bus.out_r     = w_out_valid ? r_mem_r[r_rd_ptr]   : '0;
    assign bus.out_tag   = w_out_valid ? r_mem_tag[r_rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trk_vld <= '0;
        end else begin
            r_trk_vld[0] <= w_accept;
            for (int i = 1; i < STAGES; i++) begin
                r_trk_vld[i] <= r_trk_vld[i-1];
            end
        end
    end

    // Tags ride alongside the valids; stale tags are harmless once valids clear.
    always_ff @(posedge clk) begin
        r_trk_tag[0] <= bus.in_tag;
        for (int i = 1; i < STAGES; i++) begin
            r_trk_tag[i] <= r_trk_tag[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_r[r_wr_ptr]   <= bus.alu_r;
            r_mem_tag[r_wr_ptr] <= r_trk_tag[STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_wr, w_pop})
                2'b10:   r_occ <= r_occ + CNT_W'(1);
                2'b01:   r_occ <= r_occ - CNT_W'(1);
                default: r_occ <= r_occ;
            endcase
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_wr && w_full));

endmodule

// File: tb/tb_alu_mc_ctrl.sv
// Directed bench for alu_mc_ctrl with a behavioural 3-stage ALU and an
// in-order scoreboard keyed on the expected arrival cycle of each result.
module tb_alu_mc_ctrl;
  localparam int STAGES = 3;
  localparam int DEPTH  = 4;
  localparam int TAG_W  = 4;

  typedef struct {
    logic             sel;
    logic [31:0]      a;
    logic [31:0]      b;
    logic             c;
    logic [TAG_W-1:0] tag;
    logic [31:0]      r;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;

  logic [TAG_W+31:0] exp_q[$];
  int                rdy_q[$];
  logic              acc_flag = 1'b0;
  logic              use_tbl  = 1'b0;
  logic [31:0]       tbl_exp  = '0;
  vec_t              tbl[10];

  alu_mc_ctrl_if #(.TAG_W(TAG_W)) bus();

  alu_mc_ctrl #(.STAGES(STAGES), .FIFO_DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset-free ALU model
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] alu_pipe[STAGES];
  always @(posedge clk) begin
    alu_pipe[0] <= bus.alu_sel ? bus.alu_a + bus.alu_b + {31'b0, bus.alu_c}
                               : bus.alu_a - bus.alu_b - {31'b0, bus.alu_c};
    for (int i = 1; i < STAGES; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign bus.alu_r = alu_pipe[STAGES-1];

  function automatic logic [31:0] ref_alu(input logic sel, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
    return sel ? a + b + {31'b0, c} : a - b - {31'b0, c};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard: checks every cycle at negedge, then models this cycle's pop/accept
  always @(negedge clk) begin
    bit exp_rdy;
    bit exp_v;
    if (rst) begin
      exp_q.delete();
      rdy_q.delete();
      acc_flag = 1'b0;
      chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_r",     bus.out_r,          32'd0);
      chk("rst_out_tag",   32'(bus.out_tag),   32'd0);
    end else begin
      exp_rdy = (exp_q.size() < DEPTH);
      exp_v   = (exp_q.size() > 0) && (rdy_q[0] <= cyc);
      chk("in_ready",  32'(bus.in_ready),  32'(exp_rdy));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
      if (exp_v) begin
        chk("out_r",   bus.out_r,        exp_q[0][31:0]);
        chk("out_tag", 32'(bus.out_tag), 32'(exp_q[0][TAG_W+31:32]));
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          void'(rdy_q.pop_front());
        end
      end
      acc_flag = bus.in_valid && exp_rdy;
      if (acc_flag) begin
        exp_q.push_back({bus.in_tag, use_tbl ? tbl_exp
                         : ref_alu(bus.in_sel, bus.in_a, bus.in_b, bus.in_c)});
        rdy_q.push_back(cyc + 1 + STAGES);
      end
    end
  end

  // driver tasks
  task automatic junk_inputs();
    bus.in_sel = 1'($urandom_range(0, 1));
    bus.in_a   = $urandom;
    bus.in_b   = $urandom;
    bus.in_c   = 1'($urandom_range(0, 1));
    bus.in_tag = TAG_W'($urandom_range(0, 15));
  endtask

  task automatic send_op(input logic sel, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic [TAG_W-1:0] tag);
    bus.in_sel = sel; bus.in_a = a; bus.in_b = b; bus.in_c = c; bus.in_tag = tag;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (acc_flag) begin
        bus.in_valid = 1'b0;
        junk_inputs();
        return;
      end
    end
    n_checks++;
    n_err++;
    $display("FAIL accept_timeout: tag %0d not accepted within 40 cycles", tag);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (exp_q.size() == 0) return;
      @(posedge clk); #1;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 32'd5,        32'd3,        1'b1, 4'd2,  32'd9};
    tbl[1] = '{1'b0, 32'd0,        32'd1,        1'b0, 4'd3,  32'hFFFF_FFFF};
    tbl[2] = '{1'b1, 32'hFFFF_FFFF, 32'd1,       1'b0, 4'd4,  32'h0000_0000};
    tbl[3] = '{1'b1, 32'h7FFF_FFFF, 32'd1,       1'b0, 4'd5,  32'h8000_0000};
    tbl[4] = '{1'b0, 32'd10,       32'd3,        1'b1, 4'd6,  32'd6};
    tbl[5] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd7, 32'hFFFF_FFFF};
    tbl[6] = '{1'b0, 32'd0,        32'd0,        1'b1, 4'd8,  32'hFFFF_FFFF};
    tbl[7] = '{1'b0, 32'h1234_5678, 32'h0234_5678, 1'b0, 4'd9, 32'h1000_0000};
    tbl[8] = '{1'b1, 32'd0,        32'd0,        1'b0, 4'd10, 32'd0};
    tbl[9] = '{1'b0, 32'h8000_0000, 32'd1,       1'b0, 4'd15, 32'h7FFF_FFFF};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_sel = 1'b0; bus.in_a = '0; bus.in_b = '0;
    bus.in_c = 1'b0; bus.in_tag = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // single ops from the table, each drained before the next
    for (int i = 0; i < 10; i++) begin
      use_tbl = 1'b1;
      tbl_exp = tbl[i].r;
      send_op(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].tag);
      use_tbl = 1'b0;
      drain();
      idle(2);
    end

    // streaming, 16 back-to-back
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++)
      send_op(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)), TAG_W'(i));
    drain();
    idle(2);

    // backpressure: valid held high with the consumer stalled
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      junk_inputs();
      bus.in_tag   = TAG_W'(i);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    idle(3);
    bus.out_ready = 1'b1;
    drain();
    idle(2);

    // gaps with junk operands and a flaky consumer
    for (int i = 0; i < 30; i++) begin
      junk_inputs();
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    idle(2);

    // asynchronous reset with 2 buffered and 2 in flight
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send_op(1'b1, 32'(100 + i), 32'd1, 1'b0, TAG_W'(12 + i));
    @(posedge clk); #2;
    chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    chk("pre_rst_in_ready",  32'(bus.in_ready),  32'd0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("async_rst_out_r",     bus.out_r,          32'd0);
    @(posedge clk); #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    use_tbl = 1'b1;
    tbl_exp = 32'd30;
    send_op(1'b0, 32'd50, 32'd19, 1'b1, 4'd11);
    use_tbl = 1'b0;
    drain();
    idle(6);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
